xmemport: RTL and testbench

Memory-port sequencer directly downstream of the Versat address generator. Consumes the generator's `addr`/`mem_en`/`done` stream and drives one single-port synchronous RAM. In read mode it returns the data as a registered, validated stream to the datapath; in write mode it stores datapath words. It also buffers across `pause` and reports completion only when its pipeline has drained.

---
 rtl/xmemport.sv | 140 ++++++++++++++
 tb/tb_xmemport.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xmemport.sv
// rtl/xmemport.sv - memory-port sequencer between the Versat address generator and a single-port RAM
//
// Sequences generator requests (addr_in/en_in/done_in) onto one synchronous
// single-port RAM. Read mode returns RAM words as a registered data_out /
// data_valid stream. Write mode stores data_in. A one-word skid register
// holds a read returning across a pause. done rises only when the read
// pipeline has drained.
//
// Optional feature: define XMEMPORT_BOUNDS_CHK_EN to suppress accesses with
// addr_in >= addr_limit and raise the sticky err flag. When it is undefined,
// addr_limit is ignored and err is tied low.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   run, pause, wr_mode             start pulse, global stall, 0=read/1=write
//   addr_in, en_in, done_in         generator address stream
//   data_in                         write data, aligned with en_in
//   addr_limit                      exclusive address bound (bounds check only)
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata            RAM request / read data (1-cycle latency)
//   data_out, data_valid            registered read result stream
//   acc_cnt                         saturating count of accesses since run
//   done                            idle and drained
//   err                             sticky out-of-bounds flag
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 10
`endif

module xmemport #(
   parameter int MEM_ADDR_W = `MEM_ADDR_W,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  pause,
   input  logic                  wr_mode,
   input  logic [MEM_ADDR_W-1:0] addr_in,
   input  logic                  en_in,
   input  logic                  done_in,
   input  logic [DATA_W-1:0]     data_in,
   input  logic [MEM_ADDR_W-1:0] addr_limit,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [MEM_ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata,
   output logic [DATA_W-1:0]     data_out,
   output logic                  data_valid,
   output logic [MEM_ADDR_W-1:0] acc_cnt,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

   state_t            state;
   logic              mode_r;
   logic              s1;
   logic              skid_v;
   logic [DATA_W-1:0] skid;
   logic              oob;

`ifdef XMEMPORT_BOUNDS_CHK_EN
   assign oob = addr_in >= addr_limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if (run)
         err <= 1'b0;
      else if (en_in && !pause && (state != S_IDLE) && oob)
         err <= 1'b1;
   end
`else
   logic unused_limit;
   assign unused_limit = ^addr_limit;
   assign oob          = 1'b0;
   assign err          = 1'b0;
`endif

   // Generator outputs are already registered, so the request path is pure logic.
   assign ram_en    = en_in & ~pause & (state != S_IDLE) & ~oob;
   assign ram_we    = ram_en & mode_r;
   assign ram_addr  = addr_in;
   assign ram_wdata = data_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         mode_r     <= 1'b0;
         acc_cnt    <= '0;
         done       <= 1'b1;
         s1         <= 1'b0;
         skid_v     <= 1'b0;
         skid       <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         // run restarts from any state and wins over done_in.
         if (run) begin
            state   <= S_ACTIVE;
            mode_r  <= wr_mode;
            acc_cnt <= '0;
         end else begin
            case (state)
               S_ACTIVE: if (done_in && !ram_en) state <= S_DRAIN;
               S_DRAIN:  if (!s1 && !skid_v) state <= S_IDLE;
               default:  ;
            endcase
            if (ram_en && (acc_cnt != '1))
               acc_cnt <= acc_cnt + 1'b1;
         end

         done <= (state == S_IDLE) && !run;

         if (!pause) begin
            s1 <= ram_en & ~mode_r;
            // The skid word was captured during the pause; any read issued
            // this cycle only returns next cycle, so the two never collide.
            if (skid_v) begin
               data_out   <= skid;
               data_valid <= 1'b1;
               skid_v     <= 1'b0;
            end else if (s1) begin
               data_out   <= ram_rdata;
               data_valid <= 1'b1;
            end else begin
               data_valid <= 1'b0;
            end
         end else if (s1) begin
            // RAM word arrives on the first paused cycle; park it.
            skid   <= ram_rdata;
            skid_v <= 1'b1;
            s1     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xmemport.sv
// tb/tb_xmemport.sv - scoreboard testbench for xmemport
module tb_xmemport;
   localparam int AW = 4;
   localparam int DW = 16;
`ifdef XMEMPORT_BOUNDS_CHK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          run, pause, wr_mode, en_in, done_in;
   logic [AW-1:0] addr_in, addr_limit;
   logic [DW-1:0] data_in;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic [AW-1:0] acc_cnt;
   logic          done, err;

   always #5 clk = ~clk;

   xmemport #(.MEM_ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .run(run), .pause(pause), .wr_mode(wr_mode),
      .addr_in(addr_in), .en_in(en_in), .done_in(done_in), .data_in(data_in),
      .addr_limit(addr_limit), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .data_out(data_out), .data_valid(data_valid), .acc_cnt(acc_cnt),
      .done(done), .err(err)
   );

   // Environment RAM: single port, synchronous read.
   logic [DW-1:0] ram [0:15];
   always @(posedge clk)
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else        ram_rdata     <= ram[ram_addr];
      end

   typedef struct {logic [DW-1:0] d; int t;} exp_t;
   exp_t          q[$];
   logic [DW-1:0] ref_mem [0:15];
   bit            ph [0:8191];
   int            cyc = 1;
   int            vectors = 0;
   int            miscompares = 0;
   int            we_cnt = 0;
   bit            m_active = 0, m_mode = 0, m_err = 0;
   int            m_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (ram_we) we_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: a valid word is new unless the previous cycle was paused (hold).
   always @(negedge clk) begin
      if (!rst && data_valid && !ph[cyc-1]) begin
         if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid: data_out %0h with no read pending (cycle %0d)", data_out, cyc);
         end else begin
            exp_t e;
            int   u;
            e = q.pop_front();
            u = e.t + 1;
            while (ph[u]) u++;
            chk("rd_data", data_out, e.d);
            chk("rd_latency", cyc, u + 1);
         end
      end
   end

   task automatic step(input bit r, input bit en, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit p, input bit dn);
      @(posedge clk);
      #1;
      run = r; en_in = en; addr_in = a; data_in = d; pause = p; done_in = dn;
      ph[cyc] = p;
      if (r) begin
         m_active = 1; m_mode = wr_mode; m_cnt = 0; m_err = 0;
      end else if (m_active && en && !p) begin
         if (BOUNDS && (a >= addr_limit)) m_err = 1;
         else begin
            if (m_cnt < 15) m_cnt++;
            if (m_mode) ref_mem[a] = d;
            else q.push_back('{ref_mem[a], cyc});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic start(input bit mode);
      wr_mode = mode;
      step(1, 0, 0, 0, 0, 0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && !done; i++) idle(1);
      chk("done_timeout", done, 1);
      chk("acc_cnt", acc_cnt, m_cnt);
      chk("err", err, m_err);
      chk("queue_empty", q.size(), 0);
   endtask

   initial begin
      rst = 1; run = 0; pause = 0; wr_mode = 0; en_in = 0; done_in = 0;
      addr_in = 0; data_in = 0; addr_limit = 12;
      for (int i = 0; i < 16; i++) ref_mem[i] = 'x;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_out", data_out, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_acc_cnt", acc_cnt, 0);
      chk("rst_done", done, 1);
      chk("rst_err", err, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      rst = 0;

      // Preload every word with i+100 through write mode; 16 accesses saturate acc_cnt.
      start(1);
      idle(1);
      chk("done_fall", done, 0);
      for (int i = 0; i < 16; i++) step(0, 1, AW'(i), DW'(i + 100), 0, 0);
      step(0, 0, 0, 0, 0, 1);
      wait_done();
      chk("acc_sat", acc_cnt, 15);

      // Read burst 0..7, done_in after the burst; done rises 3 cycles later.
      start(0);
      for (int i = 0; i < 8; i++) step(0, 1, AW'(i), 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("burst_acc_cnt", acc_cnt, 8);
      idle(2);
      chk("burst_done_lo", done, 0);
      idle(1);
      chk("burst_done_hi", done, 1);
      wait_done();

      // Pause skid: 3 paused cycles right after the request for address 2.
      start(0);
      for (int i = 0; i < 3; i++) step(0, 1, AW'(i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 3, 0, 1, 0);
      for (int i = 3; i < 8; i++) step(0, 1, AW'(i), 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      wait_done();

      // Write burst A0..A3 to addresses 0..3.
      we_cnt = 0;
      start(1);
      for (int i = 0; i < 4; i++) step(0, 1, AW'(i), DW'(16'hA0 + i), 0, 0);
      step(0, 0, 0, 0, 0, 1);
      idle(3);
      chk("wr_done_hi", done, 1);
      chk("wr_we_pulses", we_cnt, 4);
      for (int i = 0; i < 4; i++) chk("wr_ram", ram[i], 16'hA0 + i);
      wait_done();

      // Restart during DRAIN with a word parked in the skid register.
      start(0);
      for (int i = 4; i < 8; i++) step(0, 1, AW'(i), 0, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      start(0);
      idle(1);
      chk("b2b_acc_clr", acc_cnt, 0);
      chk("b2b_done_lo1", done, 0);
      idle(2);
      chk("b2b_done_lo2", done, 0);
      step(0, 0, 0, 0, 0, 1);
      wait_done();

      // Asynchronous reset in the middle of a read burst.
      start(0);
      for (int i = 0; i < 4; i++) step(0, 1, AW'(i), 0, 0, 0);
      #3 rst = 1;
      #1;
      chk("arst_data_valid", data_valid, 0);
      chk("arst_data_out", data_out, 0);
      chk("arst_acc_cnt", acc_cnt, 0);
      chk("arst_done", done, 1);
      chk("arst_err", err, 0);
      chk("arst_ram_en", ram_en, 0);
      q.delete();
      m_active = 0;
      m_cnt = 0;
      @(posedge clk);
      #1 rst = 0;
      en_in = 0;
      idle(4);
      chk("arst_idle_done", done, 1);

`ifdef XMEMPORT_BOUNDS_CHK_EN
      addr_limit = 4;
      start(0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, AW'(i), 0, 0, 0);
         if (i == 4) chk("bnd_err_pre", err, 0);
         if (i == 5) chk("bnd_err_set", err, 1);
      end
      step(0, 0, 0, 0, 0, 1);
      wait_done();
      chk("bnd_acc", acc_cnt, 4);
      start(0);
      idle(1);
      chk("bnd_err_clr", err, 0);
      step(0, 0, 0, 0, 0, 1);
      wait_done();
      addr_limit = 12;
`endif

      // Randomized runs against the reference model.
      for (int r = 0; r < 8; r++) begin
         int n;
         start(1'($urandom_range(0, 1)));
         n = $urandom_range(5, 25);
         for (int i = 0; i < n; i++)
            step(0, ($urandom % 4) != 0, AW'($urandom), DW'($urandom),
                 ($urandom % 5) == 0, 0);
         step(0, 0, 0, 0, 0, 1);
         wait_done();
      end
      for (int i = 0; i < (BOUNDS ? 12 : 16); i++) chk("final_ram", ram[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
